// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: pops 16-bit samples from a FIFO and serialises them as
// Philips I2S (one-bit delay after ws), left then right, 32 BCLK slots per frame.
module i2s_tx_serializer #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  output logic        bclk,
  output logic        ws,
  output logic        sd,
  output logic        busy,
  output logic        underrun
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  div;
  logic [4:0]  slot;
  logic [4:0]  slot_next;
  logic [15:0] hold;
  logic [15:0] shift;
  logic        rd_q;
  logic        div_wrap;
  logic        fall;
  logic        fetch;

  assign div_wrap  = (div == DIV_LAST);
  assign fall      = div_wrap && bclk;
  assign slot_next = slot + 5'd1;

  // Fetch window is the very first clk of slot 0 (left) and slot 16 (right).
  assign fetch   = (state == RUN) && ((slot == 5'd0) || (slot == 5'd16)) &&
                   (div == 8'd0) && !bclk;
  assign fifo_rd = fetch && !fifo_empty;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div      <= '0;
      slot     <= '0;
      hold     <= '0;
      shift    <= '0;
      rd_q     <= 1'b0;
      bclk     <= 1'b0;
      ws       <= 1'b0;
      sd       <= 1'b0;
      underrun <= 1'b0;
    end else begin
      // FIFO data arrives one clk after the strobe; an empty fetch substitutes silence.
      rd_q <= fifo_rd;
      if (rd_q) begin
        hold <= fifo_data;
      end
      if (fetch && fifo_empty) begin
        hold     <= '0;
        underrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          div   <= '0;
          slot  <= '0;
          bclk  <= 1'b0;
          ws    <= 1'b0;
          sd    <= 1'b0;
          shift <= '0;
          if (en) begin
            state <= RUN;
          end
        end

        RUN, FINISH: begin
          div <= div_wrap ? 8'd0 : div + 8'd1;
          if (div_wrap) begin
            bclk <= ~bclk;
          end
          if (fall) begin
            if (state == FINISH) begin
              state <= IDLE;
              slot  <= '0;
              ws    <= 1'b0;
              sd    <= 1'b0;
              shift <= '0;
            end else begin
              slot <= slot_next;
              ws   <= slot_next[4];
              // MSB goes out one slot after ws changes, hence the load at slots 1 and 17.
              if ((slot_next == 5'd1) || (slot_next == 5'd17)) begin
                sd    <= hold[15];
                shift <= {hold[14:0], 1'b0};
              end else begin
                sd    <= shift[15];
                shift <= {shift[14:0], 1'b0};
              end
              if ((slot == 5'd31) && !en) begin
                state <= FINISH;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2s_tx_serializer.md
I2S_TX_SERIALIZER -- requirements
Module: i2s_tx_serializer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving the clk cycles per BCLK half-period; the legal range is 2 to 255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit: transmit enable.
REQ-005 The block SHALL have port fifo_data, input, 16 bits: sample word from the FIFO; valid one clk after fifo_rd.
REQ-006 The block SHALL have port fifo_empty, input, 1 bit: FIFO holds no samples.
REQ-007 The block SHALL have port fifo_rd, output, 1 bit: one-cycle read strobe that pops one sample.
REQ-008 The block SHALL have port bclk, output, 1 bit: I2S bit clock.
REQ-009 The block SHALL have port ws, output, 1 bit: I2S word select (0 = left, 1 = right).
REQ-010 The block SHALL have port sd, output, 1 bit: I2S serial data, MSB first.
REQ-011 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 The block SHALL have port underrun, output, 1 bit: sticky flag set when a sample was needed while the FIFO was empty.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and FINISH.
REQ-014 IDLE SHALL go to RUN on the clk after en is sampled high; the first RUN cycle SHALL be the first cycle of slot 0.
REQ-015 In IDLE, bclk, ws, sd and fifo_rd SHALL be 0 and the divider SHALL be held at 0.
REQ-016 Divider: in RUN/FINISH the divider SHALL count 0..CLK_DIV-1, and bclk SHALL toggle on each wrap; bclk is 0 for the first half of every slot.
REQ-017 Slots: a frame SHALL be 32 slots (0..31) of one BCLK period each, and the slot counter SHALL advance on each bclk falling edge.
REQ-018 ws SHALL be 0 for slots 0..15 and 1 for slots 16..31, and SHALL change only together with a bclk falling edge.
REQ-019 Data alignment (one-bit I2S delay): left MSB..LSB SHALL occupy slots 1..16; right MSB..LSB SHALL occupy slots 17..31 plus slot 0 of the next frame.
REQ-020 sd in slot 0 of the first frame after IDLE SHALL be 0.
REQ-021 sd SHALL change only on bclk falling edges (and on RUN entry), so it is stable at every bclk rising edge.
REQ-022 Fetch: in the first clk cycle of slot 0 and of slot 16, fifo_rd SHALL be 1 if fifo_empty=0, and 0 otherwise.
REQ-023 Hold register: fifo_data SHALL be captured into the hold register exactly one clk after fifo_rd=1.
REQ-024 The shift register SHALL load from the hold register at the falling edge that starts slot 1 (left) or slot 17 (right).
REQ-025 Underrun: if fifo_empty=1 in a fetch cycle, the hold register SHALL be loaded with 16'h0000, fifo_rd SHALL stay 0, and underrun SHALL be set.
REQ-026 Underrun SHALL stay set until rst; transmission SHALL continue with the zero sample.
REQ-027 fifo_rd SHALL never exceed 2 pulses per frame and SHALL never assert in IDLE or FINISH.
REQ-028 If en is 0 when slot 31 ends, RUN SHALL go to FINISH; otherwise the next frame SHALL start at slot 0 with a new left fetch.
REQ-029 FINISH SHALL output slot 0 (right LSB, ws=0) for one full BCLK period, with no fetch, then go to IDLE with bclk=0.
REQ-030 Deasserting and reasserting en within a frame SHALL have no effect; en is sampled only at the end of slot 31.
REQ-031 No sample SHALL be dropped or duplicated: each fifo_rd pop SHALL be transmitted exactly once.

Reset
REQ-032 When rst=1 on a clk edge, the block SHALL enter IDLE and clear the divider, slot counter, hold and shift registers and underrun, and drive fifo_rd, bclk, ws, sd and busy to 0.
REQ-033 Reset SHALL take precedence over en and SHALL abort a frame mid-operation with no FINISH slot.

Verification
REQ-034 The bench SHALL cover, with CLK_DIV=2, FIFO preloaded with 16'hA5F0, 16'h0FFF, en=1: fifo_rd pulses in the first cycle of slot 0 and slot 16; bits sampled on bclk rising edges are 1010010111110000 with ws=0 in slots 1..16 and 0000111111111111 across slots 17..31 plus next slot 0; bclk period is 4 clk.
REQ-035 The bench SHALL cover an empty FIFO with en=1: fifo_rd stays 0, sd stays 0 for the whole frame, underrun=1 from the cycle after the slot-0 fetch, and underrun stays 1 after refill.
REQ-036 The bench SHALL cover en dropped at slot 5 with FIFO holding 4 samples: the frame completes, FINISH emits the right LSB in slot 0, then IDLE with busy=0; exactly 2 pops and 2 samples remain.
REQ-037 The bench SHALL cover rst asserted at slot 20: on the next clk all outputs are 0 and state is IDLE; after rst release with en=1, the frame starts with slot-0 sd=0 and a fresh left fetch.
REQ-038 The bench SHALL cover continuous streaming of 64 random samples for 32 frames with CLK_DIV=3: the decoded output matches the FIFO order exactly, 64 fifo_rd pulses are seen, and ws toggles only on bclk falling edges.
